// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage sitting directly in front of the IF/ID pipeline register. It
// owns the program counter, issues one request per cycle to a program memory
// with a 1-cycle synchronous read, and presents the returned instruction and
// its PC to IF/ID. A hazard stall freezes the presented instruction; an
// EX-stage redirect squashes the wrong-path response in flight and restarts
// fetching at the (word-aligned) target. Flushing whatever is already inside
// IF/ID is the hazard unit's job, not this block's.
//
// Ports
//   Clk                      in   1   clock, all state on rising edge
//   Reset                    in   1   asynchronous, active-high
//   Stall_IF                 in   1   hold current output, issue no new fetch
//   Redirect_EX              in   1   taken branch/jump resolved in EX
//   Redirect_Target_EX       in  32   redirect target (bits [1:0] ignored)
//   IMem_Req                 out  1   fetch request this cycle
//   IMem_Addr                out 32   fetch address, word aligned
//   IMem_Rdata               in  32   data for the previous cycle's request
//   Instruction_Fetch_IF_PM  out 32   instruction to IF/ID
//   PC_IF                    out 32   PC of Instruction_Fetch_IF_PM
//   Valid_IF                 out  1   1 = real instruction, 0 = NOP bubble
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall_IF,
    input  logic        Redirect_EX,
    input  logic [31:0] Redirect_Target_EX,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Rdata,
    output logic [31:0] Instruction_Fetch_IF_PM,
    output logic [31:0] PC_IF,
    output logic        Valid_IF
);

    // EMPTY: nothing valid on IMem_Rdata (after reset)
    // RUN  : IMem_Rdata holds the response for resp_pc_r
    // HOLD : stalled, the presented instruction lives in the hold buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] fetch_pc_r;   // next address to request
    logic [31:0] resp_pc_r;    // PC of the response currently on IMem_Rdata
    logic [31:0] hold_instr_r;
    logic [31:0] hold_pc_r;

    logic [31:0] target_s;

    // Redirect targets are forced onto a word boundary.
    assign target_s = {Redirect_Target_EX[31:2], 2'b00};

    // Memory request: redirect beats stall; nothing is requested during reset.
    always_comb begin
        IMem_Req  = 1'b0;
        IMem_Addr = fetch_pc_r;
        if (Reset) begin
            IMem_Req  = 1'b0;
            IMem_Addr = fetch_pc_r;
        end else if (Redirect_EX) begin
            IMem_Req  = 1'b1;
            IMem_Addr = target_s;
        end else if (Stall_IF) begin
            IMem_Req  = 1'b0;
            IMem_Addr = fetch_pc_r;
        end else begin
            IMem_Req  = 1'b1;
            IMem_Addr = fetch_pc_r;
        end
    end

    // Output selection. RUN forwards the memory's own registered read data so
    // the fetch latency stays at one cycle; a redirect squashes that response.
    always_comb begin
        Instruction_Fetch_IF_PM = NOP_INSTR;
        PC_IF                   = resp_pc_r;
        Valid_IF                = 1'b0;
        if (Reset || Redirect_EX) begin
            Instruction_Fetch_IF_PM = NOP_INSTR;
            PC_IF                   = resp_pc_r;
            Valid_IF                = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    Instruction_Fetch_IF_PM = IMem_Rdata;
                    PC_IF                   = resp_pc_r;
                    Valid_IF                = 1'b1;
                end
                HOLD: begin
                    Instruction_Fetch_IF_PM = hold_instr_r;
                    PC_IF                   = hold_pc_r;
                    Valid_IF                = 1'b1;
                end
                EMPTY: begin
                    Instruction_Fetch_IF_PM = NOP_INSTR;
                    PC_IF                   = resp_pc_r;
                    Valid_IF                = 1'b0;
                end
                default: begin
                    Instruction_Fetch_IF_PM = NOP_INSTR;
                    PC_IF                   = resp_pc_r;
                    Valid_IF                = 1'b0;
                end
            endcase
        end
    end

    // PC, response tracking, stall buffer and state update.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= EMPTY;
            fetch_pc_r   <= RESET_PC;
            resp_pc_r    <= RESET_PC;
            hold_instr_r <= 32'h0000_0000;
            hold_pc_r    <= 32'h0000_0000;
        end else if (Redirect_EX) begin
            // Target is requested this cycle; wrap-around is intentional.
            state_r      <= RUN;
            resp_pc_r    <= target_s;
            fetch_pc_r   <= target_s + 32'd4;
            hold_instr_r <= 32'h0000_0000;
            hold_pc_r    <= 32'h0000_0000;
        end else if (Stall_IF) begin
            case (state_r)
                RUN: begin
                    // Capture now: IMem_Rdata is not guaranteed to persist.
                    hold_instr_r <= IMem_Rdata;
                    hold_pc_r    <= resp_pc_r;
                    state_r      <= HOLD;
                end
                HOLD: begin
                    state_r <= HOLD;
                end
                EMPTY: begin
                    state_r <= EMPTY;
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end else begin
            // Release from HOLD lands here too: the held word is shown this
            // cycle while fetch_pc_r is requested, so nothing is lost.
            state_r    <= RUN;
            resp_pc_r  <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + 32'd4;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk;
    logic        Reset;
    logic        Stall_IF;
    logic        Redirect_EX;
    logic [31:0] Redirect_Target_EX;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic [31:0] IMem_Rdata;
    logic [31:0] Instruction_Fetch_IF_PM;
    logic [31:0] PC_IF;
    logic        Valid_IF;

    int tests_run;
    int tests_failed;

    instruction_fetch_stage dut (
        .Clk                     (Clk),
        .Reset                   (Reset),
        .Stall_IF                (Stall_IF),
        .Redirect_EX             (Redirect_EX),
        .Redirect_Target_EX      (Redirect_Target_EX),
        .IMem_Req                (IMem_Req),
        .IMem_Addr               (IMem_Addr),
        .IMem_Rdata              (IMem_Rdata),
        .Instruction_Fetch_IF_PM (Instruction_Fetch_IF_PM),
        .PC_IF                   (PC_IF),
        .Valid_IF                (Valid_IF)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Program memory: word[n] = 0x100 + n, 1-cycle synchronous read.
    initial IMem_Rdata = 32'h0;
    always @(posedge Clk) begin
        if (IMem_Req)
            IMem_Rdata <= 32'h100 + {2'b00, IMem_Addr[31:2]};
    end

    task automatic chk_out(input string tag, input logic [31:0] e_instr,
                           input logic [31:0] e_pc, input logic e_valid);
        tests_run++;
        assert (Instruction_Fetch_IF_PM === e_instr && PC_IF === e_pc && Valid_IF === e_valid)
        else begin
            tests_failed++;
            $error("FAIL %s: observed instr=%h pc=%h valid=%b expected instr=%h pc=%h valid=%b",
                   tag, Instruction_Fetch_IF_PM, PC_IF, Valid_IF, e_instr, e_pc, e_valid);
        end
    endtask

    task automatic chk_req(input string tag, input logic e_req, input logic [31:0] e_addr);
        tests_run++;
        assert (IMem_Req === e_req && IMem_Addr === e_addr)
        else begin
            tests_failed++;
            $error("FAIL %s: observed req=%b addr=%h expected req=%b addr=%h",
                   tag, IMem_Req, IMem_Addr, e_req, e_addr);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        Reset = 1'b1;
        Stall_IF = 1'b0;
        Redirect_EX = 1'b0;
        Redirect_Target_EX = 32'h0;

        // Reset state
        @(negedge Clk); #1;
        chk_out("reset_out", NOP, 32'h0, 1'b0);
        chk_req("reset_req", 1'b0, 32'h0);

        // Release: first cycle is a bubble requesting RESET_PC
        Reset = 1'b0; #1;
        chk_out("first_bubble", NOP, 32'h0, 1'b0);
        chk_req("first_req", 1'b1, 32'h0);

        @(negedge Clk); #1;
        chk_out("run_pc0", 32'h100, 32'h0, 1'b1);
        chk_req("run_req4", 1'b1, 32'h4);
        @(negedge Clk); #1;
        chk_out("run_pc4", 32'h101, 32'h4, 1'b1);

        // Stall 3 cycles while (8, 0x102) is shown
        @(negedge Clk); Stall_IF = 1'b1; #1;
        chk_out("stall1", 32'h102, 32'h8, 1'b1);
        chk_req("stall1_req", 1'b0, 32'hC);
        @(negedge Clk); #1;
        chk_out("stall2", 32'h102, 32'h8, 1'b1);
        chk_req("stall2_req", 1'b0, 32'hC);
        @(negedge Clk); #1;
        chk_out("stall3", 32'h102, 32'h8, 1'b1);
        @(negedge Clk); Stall_IF = 1'b0; #1;
        chk_out("release", 32'h102, 32'h8, 1'b1);
        chk_req("release_req", 1'b1, 32'hC);
        @(negedge Clk); #1;
        chk_out("after_release", 32'h103, 32'hC, 1'b1);

        // Redirect to 0x40 in the cycle PC 12 is shown
        Redirect_EX = 1'b1; Redirect_Target_EX = 32'h40; #1;
        chk_out("redir40_bubble", NOP, 32'hC, 1'b0);
        chk_req("redir40_req", 1'b1, 32'h40);
        @(negedge Clk); Redirect_EX = 1'b0; #1;
        chk_out("redir40_tgt", 32'h110, 32'h40, 1'b1);
        @(negedge Clk); #1;
        chk_out("redir40_next", 32'h111, 32'h44, 1'b1);

        // Redirect to unaligned 0x83 together with stall: redirect wins
        @(negedge Clk); Redirect_EX = 1'b1; Redirect_Target_EX = 32'h83; Stall_IF = 1'b1; #1;
        chk_out("redir83_bubble", NOP, 32'h48, 1'b0);
        chk_req("redir83_req", 1'b1, 32'h80);
        @(negedge Clk); Redirect_EX = 1'b0; Stall_IF = 1'b0; #1;
        chk_out("redir83_tgt", 32'h120, 32'h80, 1'b1);
        @(negedge Clk); #1;
        chk_out("redir83_next", 32'h121, 32'h84, 1'b1);

        // Redirect near top of address space: PC wraps to 0
        @(negedge Clk); Redirect_EX = 1'b1; Redirect_Target_EX = 32'hFFFF_FFF8; #1;
        chk_out("wrap_bubble", NOP, 32'h88, 1'b0);
        @(negedge Clk); Redirect_EX = 1'b0; #1;
        chk_out("wrap_f8", 32'h4000_00FE, 32'hFFFF_FFF8, 1'b1);
        @(negedge Clk); #1;
        chk_out("wrap_fc", 32'h4000_00FF, 32'hFFFF_FFFC, 1'b1);
        chk_req("wrap_req0", 1'b1, 32'h0);
        @(negedge Clk); #1;
        chk_out("wrap_0", 32'h100, 32'h0, 1'b1);

        // Enter HOLD, then pulse reset mid-cycle
        @(negedge Clk); Stall_IF = 1'b1; #1;
        chk_out("hold_enter", 32'h101, 32'h4, 1'b1);
        @(negedge Clk); #1;
        chk_out("hold_kept", 32'h101, 32'h4, 1'b1);
        #1; Reset = 1'b1; #1;
        chk_out("async_reset_out", NOP, 32'h0, 1'b0);
        chk_req("async_reset_req", 1'b0, 32'h0);
        @(negedge Clk); Reset = 1'b0; Stall_IF = 1'b0; #1;
        chk_out("restart_bubble", NOP, 32'h0, 1'b0);
        chk_req("restart_req", 1'b1, 32'h0);
        @(negedge Clk); #1;
        chk_out("restart_pc0", 32'h100, 32'h0, 1'b1);
        @(negedge Clk); #1;
        chk_out("restart_pc4", 32'h101, 32'h4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
